hpdcache_mem_responder: RTL
===========================

Name: hpdcache_mem_responder

Overview:
- Memory-side responder for the HPDcache memory interface: 32-bit address, 6-bit ID, 32-bit data.
- Accepts read and write requests (single beat or incrementing burst) from the cache's miss and writeback paths.
- Serves them from a word-addressed synchronous single-port BRAM with 1-cycle read latency.
- Sits between the cache's mem ports and the on-chip RAM/UART-facing memory map.

Parameters:
- ADDR_WIDTH, 32, request address width
- ID_WIDTH, 6, transaction ID width
- DATA_WIDTH, 32, data beat width (BE width = DATA_WIDTH/8)
- MEM_WORDS, 4096, backing RAM depth in words
- BASE_ADDR, 32'h0, byte base address of the backing RAM

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- rd_req_valid_i / rd_req_ready_o  in/out  1  read request handshake
- rd_req_addr_i  in  ADDR_WIDTH  byte address of first beat
- rd_req_len_i  in  8  beats minus one
- rd_req_size_i  in  3  log2 bytes per beat
- rd_req_id_i  in  ID_WIDTH  transaction ID
- rd_req_atomic_i  in  1  atomic request flag
- rd_rsp_valid_o / rd_rsp_ready_i  out/in  1  read response handshake
- rd_rsp_data_o  out  DATA_WIDTH  read data
- rd_rsp_id_o  out  ID_WIDTH  echoed ID
- rd_rsp_error_o  out  2  00 OK, 10 SLVERR
- rd_rsp_last_o  out  1  final beat
- wr_req_valid_i / wr_req_ready_o  in/out  1  write request handshake
- wr_req_addr_i, wr_req_len_i, wr_req_size_i, wr_req_id_i, wr_req_atomic_i  in  as read  write command fields
- wr_data_valid_i / wr_data_ready_o  in/out  1  write data handshake
- wr_data_i  in  DATA_WIDTH  write data
- wr_be_i  in  DATA_WIDTH/8  byte enables
- wr_last_i  in  1  final write beat
- wr_rsp_valid_o / wr_rsp_ready_i  out/in  1  write response handshake
- wr_rsp_id_o  out  ID_WIDTH  echoed ID
- wr_rsp_error_o  out  2  write status
- wr_rsp_is_atomic_o  out  1  always 0
- mem_en_o  out  1  RAM access enable
- mem_we_o  out  1  RAM write enable
- mem_addr_o  out  $clog2(MEM_WORDS)  word address
- mem_wdata_o  out  DATA_WIDTH  RAM write data
- mem_be_o  out  DATA_WIDTH/8  RAM byte enables
- mem_rdata_i  in  DATA_WIDTH  RAM read data, valid the cycle after mem_en_o && !mem_we_o

Behaviour:
- Reset (async, rst_ni low): all valid/ready/mem_en/mem_we outputs 0; data, ID and error registers 0; FSM to IDLE; last-grant = write, so reads win first.
- FSM states: IDLE, RD_ISSUE, RD_RESP, WR_DATA, WR_RESP.
- IDLE:
  - rd_req_ready_o = 1 and wr_req_ready_o = 1 only for the granted channel.
  - If both channels are valid, grant the one not granted last (round-robin).
  - On accept, latch addr/len/id and compute err.
  - err = atomic, OR size != 2, OR any beat address outside [BASE_ADDR, BASE_ADDR + 4*MEM_WORDS), OR addr[1:0] != 0.
  - Go to RD_ISSUE (read) or WR_DATA (write).
- RD_ISSUE (1 cycle):
  - If !err: mem_en_o = 1, mem_we_o = 0, mem_addr_o = (addr - BASE_ADDR) >> 2.
  - Go to RD_RESP.
- RD_RESP:
  - On entry, capture mem_rdata_i into the response register (0 if err).
  - rd_rsp_valid_o = 1; data, id, error and last (beat counter == len) are stable until rd_rsp_ready_i.
  - On handshake: if last, go to IDLE; else addr += 4, counter++, go to RD_ISSUE.
  - Minimum 2 cycles per beat.
- WR_DATA:
  - wr_data_ready_o = 1.
  - Each accepted beat: if !err, mem_en_o = mem_we_o = 1, mem_be_o = wr_be_i, same cycle.
  - addr += 4 per beat.
  - Go to WR_RESP after the beat with wr_last_i = 1.
  - A beat count mismatch vs len (wr_last_i early or late) sets error = SLVERR. Excess beats are dropped and writing stops at wr_last_i.
- WR_RESP:
  - wr_rsp_valid_o = 1 with latched id/error, held until wr_rsp_ready_i.
  - Then go to IDLE.
- Errored transactions never touch RAM. Read data = 0. Error is SLVERR on every beat of the burst.
- Address arithmetic is ADDR_WIDTH-bit. A burst whose end wraps past 2^ADDR_WIDTH is an error.
- Write data arriving before its command is not accepted (wr_data_ready_o = 0 outside WR_DATA).
- Only one transaction is in flight; request ready stays low outside IDLE.
- Reset mid-burst aborts the transaction with no response; the RAM is unaffected beyond beats already written.

Test Plan:
- Single read: write 32'hDEADBEEF at byte 0x40, then read addr 0x40, len 0, id 5 → one rsp beat: data DEADBEEF, id 5, error 00, last 1; mem_addr_o = 0x10.
- Burst read: read addr 0x100, len 7, with rd_rsp_ready_i toggling every cycle → 8 beats of consecutive words in order, last only on beat 8, data stable while stalled.
- Write with BE: write addr 0x20, data 32'h11223344, be 4'b0101, id 3 → wr_rsp id 3, error 00; readback of an all-zero word gives 32'h00220044.
- Error: read addr 0x4000 (beyond 4096 words), len 1 → 2 beats with error 10, data 0, no mem_en_o; atomic write → SLVERR, RAM unchanged.
- Arbitration: rd and wr valid in the same cycle after reset → read granted first, write next; repeated simultaneous requests alternate.
- Reset: assert rst_ni low during beat 3 of a len 7 read → all valids drop immediately; the next request after reset is served normally.

Source files
------------

// File: rtl/hpdcache_mem_responder.sv
// rtl/hpdcache_mem_responder.sv - HPDcache memory-side responder backed by a 1-cycle-latency word RAM
// One transaction in flight; read/write requests are arbitrated round-robin in IDLE.
module hpdcache_mem_responder #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           ID_WIDTH   = 6,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           MEM_WORDS  = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         rd_req_valid_i,
    output logic                         rd_req_ready_o,
    input  logic [ADDR_WIDTH-1:0]        rd_req_addr_i,
    input  logic [7:0]                   rd_req_len_i,
    input  logic [2:0]                   rd_req_size_i,
    input  logic [ID_WIDTH-1:0]          rd_req_id_i,
    input  logic                         rd_req_atomic_i,
    output logic                         rd_rsp_valid_o,
    input  logic                         rd_rsp_ready_i,
    output logic [DATA_WIDTH-1:0]        rd_rsp_data_o,
    output logic [ID_WIDTH-1:0]          rd_rsp_id_o,
    output logic [1:0]                   rd_rsp_error_o,
    output logic                         rd_rsp_last_o,
    input  logic                         wr_req_valid_i,
    output logic                         wr_req_ready_o,
    input  logic [ADDR_WIDTH-1:0]        wr_req_addr_i,
    input  logic [7:0]                   wr_req_len_i,
    input  logic [2:0]                   wr_req_size_i,
    input  logic [ID_WIDTH-1:0]          wr_req_id_i,
    input  logic                         wr_req_atomic_i,
    input  logic                         wr_data_valid_i,
    output logic                         wr_data_ready_o,
    input  logic [DATA_WIDTH-1:0]        wr_data_i,
    input  logic [DATA_WIDTH/8-1:0]      wr_be_i,
    input  logic                         wr_last_i,
    output logic                         wr_rsp_valid_o,
    input  logic                         wr_rsp_ready_i,
    output logic [ID_WIDTH-1:0]          wr_rsp_id_o,
    output logic [1:0]                   wr_rsp_error_o,
    output logic                         wr_rsp_is_atomic_o,
    output logic                         mem_en_o,
    output logic                         mem_we_o,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0]        mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0]      mem_be_o,
    input  logic [DATA_WIDTH-1:0]        mem_rdata_i
);

    localparam int unsigned MAW  = $clog2(MEM_WORDS);
    localparam int unsigned AEXT = ADDR_WIDTH + 2;
    localparam logic [AEXT-1:0] BASE_EXT  = AEXT'(BASE_ADDR);
    localparam logic [AEXT-1:0] LIMIT_EXT = BASE_EXT + AEXT'(4 * MEM_WORDS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_RESP, WR_DATA, WR_RESP} state_e;

    state_e                  state_q, state_d;
    logic                    last_wr_q, last_wr_d;
    logic                    live_q, live_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic [8:0]              cnt_q, cnt_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic                    err_q, err_d;
    logic                    mis_q, mis_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    fresh_q, fresh_d;

    logic                    gnt_rd, gnt_wr;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [7:0]              req_len;
    logic [2:0]              req_size;
    logic [ID_WIDTH-1:0]     req_id;
    logic                    req_atomic;
    logic [AEXT-1:0]         req_first, req_end;
    logic                    req_err;
    logic [8:0]              len_ext;
    logic                    rd_last, beat_in_len;
    logic [ADDR_WIDTH-1:0]   mem_off;
    logic [DATA_WIDTH-1:0]   rd_beat_data;

    // live_q keeps both request readies low while reset is asserted
    assign gnt_rd = live_q && (state_q == IDLE) && rd_req_valid_i && (!wr_req_valid_i || last_wr_q);
    assign gnt_wr = live_q && (state_q == IDLE) && wr_req_valid_i && !gnt_rd;

    assign req_addr   = gnt_rd ? rd_req_addr_i   : wr_req_addr_i;
    assign req_len    = gnt_rd ? rd_req_len_i    : wr_req_len_i;
    assign req_size   = gnt_rd ? rd_req_size_i   : wr_req_size_i;
    assign req_id     = gnt_rd ? rd_req_id_i     : wr_req_id_i;
    assign req_atomic = gnt_rd ? rd_req_atomic_i : wr_req_atomic_i;

    // req_end is the last beat's byte address, widened so a wrap past 2^ADDR_WIDTH is visible
    assign req_first = AEXT'(req_addr);
    assign req_end   = req_first + AEXT'({req_len, 2'b00});
    assign req_err   = req_atomic || (req_size != 3'd2) || (req_addr[1:0] != 2'b00) ||
                       (req_first < BASE_EXT) || (req_end >= LIMIT_EXT) || req_end[ADDR_WIDTH];

    assign len_ext      = {1'b0, len_q};
    assign rd_last      = (cnt_q == len_ext);
    assign beat_in_len  = (cnt_q <= len_ext);
    assign mem_off      = addr_q - BASE_ADDR;
    assign rd_beat_data = err_q ? '0 : mem_rdata_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (gnt_rd)      state_d = RD_ISSUE;
                else if (gnt_wr) state_d = WR_DATA;
            end
            RD_ISSUE: state_d = RD_RESP;
            RD_RESP: begin
                if (rd_rsp_ready_i) state_d = rd_last ? IDLE : RD_ISSUE;
            end
            WR_DATA: begin
                if (wr_data_valid_i && wr_last_i) state_d = WR_RESP;
            end
            WR_RESP: begin
                if (wr_rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_req_ready_o     = gnt_rd;
        wr_req_ready_o     = gnt_wr;
        wr_data_ready_o    = (state_q == WR_DATA);
        rd_rsp_valid_o     = (state_q == RD_RESP);
        rd_rsp_data_o      = fresh_q ? rd_beat_data : rdata_q;
        rd_rsp_id_o        = id_q;
        rd_rsp_error_o     = err_q ? RESP_SLVERR : RESP_OKAY;
        rd_rsp_last_o      = (state_q == RD_RESP) && rd_last;
        wr_rsp_valid_o     = (state_q == WR_RESP);
        wr_rsp_id_o        = id_q;
        wr_rsp_error_o     = (err_q || mis_q) ? RESP_SLVERR : RESP_OKAY;
        wr_rsp_is_atomic_o = 1'b0;
        mem_en_o           = 1'b0;
        mem_we_o           = 1'b0;
        mem_addr_o         = MAW'(mem_off >> 2);
        mem_wdata_o        = '0;
        mem_be_o           = '0;
        if (state_q == RD_ISSUE && !err_q) begin
            mem_en_o = 1'b1;
        end
        // beats past len are still consumed but never reach the RAM
        if (state_q == WR_DATA && wr_data_valid_i && !err_q && beat_in_len) begin
            mem_en_o    = 1'b1;
            mem_we_o    = 1'b1;
            mem_wdata_o = wr_data_i;
            mem_be_o    = wr_be_i;
        end
    end

    always_comb begin
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        id_d      = id_q;
        err_d     = err_q;
        mis_d     = mis_q;
        rdata_d   = rdata_q;
        fresh_d   = 1'b0;
        last_wr_d = last_wr_q;
        live_d    = 1'b1;
        case (state_q)
            IDLE: begin
                if (gnt_rd || gnt_wr) begin
                    addr_d    = req_addr;
                    len_d     = req_len;
                    id_d      = req_id;
                    err_d     = req_err;
                    cnt_d     = '0;
                    mis_d     = 1'b0;
                    last_wr_d = gnt_wr;
                end
            end
            RD_ISSUE: fresh_d = 1'b1;
            RD_RESP: begin
                if (fresh_q) rdata_d = rd_beat_data;
                if (rd_rsp_ready_i && !rd_last) begin
                    addr_d = addr_q + ADDR_WIDTH'(4);
                    cnt_d  = cnt_q + 9'd1;
                end
            end
            WR_DATA: begin
                if (wr_data_valid_i) begin
                    if (beat_in_len) begin
                        addr_d = addr_q + ADDR_WIDTH'(4);
                        cnt_d  = cnt_q + 9'd1;
                    end
                    if (wr_last_i ? (cnt_q != len_ext) : (cnt_q >= len_ext)) mis_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_wr_q <= 1'b1;
            live_q    <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            id_q      <= '0;
            err_q     <= 1'b0;
            mis_q     <= 1'b0;
            rdata_q   <= '0;
            fresh_q   <= 1'b0;
        end else begin
            last_wr_q <= last_wr_d;
            live_q    <= live_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            id_q      <= id_d;
            err_q     <= err_d;
            mis_q     <= mis_d;
            rdata_q   <= rdata_d;
            fresh_q   <= fresh_d;
        end
    end

endmodule
